// File: rtl/controlador_alerta_pressao.sv
// controlador_alerta_pressao: round-robin pressure scan with confirmed, latched per-channel alarms.
// Define CONTADOR_EVENTOS_EN to add the saturating alarm-event counter output num_eventos.
module controlador_alerta_pressao #(
  parameter int N = 8,
  parameter int NUM_CANAIS = 4,
  parameter logic [N-1:0] LIMITE_BAIXO = 8'd50,
  parameter logic [N-1:0] LIMITE_ALTO = 8'd150,
  parameter int CONFIRMA = 3,
  parameter int PERIODO = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic habilita,
  input  logic [NUM_CANAIS*N-1:0] pressao_in,
  input  logic reconhece,
  output logic [$clog2(NUM_CANAIS)-1:0] canal_atual,
  output logic [2*NUM_CANAIS-1:0] alerta_canal,
  output logic [1:0] alerta,
  output logic varredura_ok
`ifdef CONTADOR_EVENTOS_EN
  , output logic [7:0] num_eventos
`endif
);
  localparam int CW = $clog2(NUM_CANAIS);
  localparam int PW = $clog2(PERIODO);
  localparam int KW = $clog2(CONFIRMA + 1);
  localparam logic [PW-1:0] ESPERA_FIM = PW'(PERIODO - NUM_CANAIS - 1);
  localparam logic [CW-1:0] ULTIMO = CW'(NUM_CANAIS - 1);
  localparam logic [KW-1:0] CONF = KW'(CONFIRMA);
  typedef enum logic [1:0] {OCIOSO, ESPERA, AMOSTRA, FIM} estado_t;
  estado_t estado, estado_prox;
  logic [PW-1:0] periodo_cnt, periodo_prox;
  logic [CW-1:0] canal_prox;
  logic amostra_en;
  logic [N-1:0] leitura;
  logic [1:0] classe_nova;
  logic [KW-1:0] conta_nova;
  logic [1:0] classe [NUM_CANAIS];
  logic [KW-1:0] conta [NUM_CANAIS];
  logic [2*NUM_CANAIS-1:0] latch, latch_prox;
  logic alto, baixo;
  always_comb begin
    estado_prox = estado;
    periodo_prox = periodo_cnt;
    canal_prox = '0;
    amostra_en = 1'b0;
    case (estado)
      OCIOSO: begin
        if (habilita) begin
          estado_prox = ESPERA;
          periodo_prox = '0;
        end
      end
      ESPERA: begin
        if (!habilita) estado_prox = OCIOSO;
        else begin
          periodo_prox = periodo_cnt + 1'b1;
          if (periodo_prox == ESPERA_FIM) estado_prox = AMOSTRA;
        end
      end
      AMOSTRA: begin
        if (!habilita) estado_prox = OCIOSO;
        else begin
          amostra_en = 1'b1;
          canal_prox = canal_atual == ULTIMO ? '0 : canal_atual + 1'b1;
          if (canal_atual == ULTIMO) estado_prox = FIM;
        end
      end
      FIM: begin
        periodo_prox = '0;
        estado_prox = habilita ? ESPERA : OCIOSO;
      end
    endcase
  end
  assign leitura = pressao_in[canal_atual*N +: N];
  always_comb begin
    classe_nova = leitura < LIMITE_BAIXO ? 2'b01 : (leitura >= LIMITE_ALTO ? 2'b10 : 2'b00);
    conta_nova = classe_nova == 2'b00 ? '0 :
                 classe_nova != classe[canal_atual] ? KW'(1) :
                 conta[canal_atual] == CONF ? CONF : conta[canal_atual] + 1'b1;
  end
  // acknowledge clears first so a confirming sample on the same edge wins
  always_comb begin
    latch_prox = latch;
    for (int i = 0; i < NUM_CANAIS; i++)
      if (reconhece && classe[i] == 2'b00) latch_prox[2*i +: 2] = 2'b00;
    if (amostra_en && conta_nova == CONF &&
        !(latch[2*canal_atual +: 2] == 2'b10 && classe_nova == 2'b01))
      latch_prox[2*canal_atual +: 2] = classe_nova;
  end
  always_comb begin
    alto = 1'b0;
    baixo = 1'b0;
    for (int i = 0; i < NUM_CANAIS; i++) begin
      alto = alto | latch[2*i+1];
      baixo = baixo | latch[2*i];
    end
  end
  assign alerta = alto ? 2'b10 : (baixo ? 2'b01 : 2'b00);
  assign alerta_canal = latch;
  assign varredura_ok = estado == FIM;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= OCIOSO;
      periodo_cnt <= '0;
      canal_atual <= '0;
      latch <= '0;
      for (int i = 0; i < NUM_CANAIS; i++) begin
        classe[i] <= 2'b00;
        conta[i] <= '0;
      end
    end else begin
      estado <= estado_prox;
      periodo_cnt <= periodo_prox;
      canal_atual <= canal_prox;
      latch <= latch_prox;
      if (amostra_en) begin
        classe[canal_atual] <= classe_nova;
        conta[canal_atual] <= conta_nova;
      end
    end
  end
`ifdef CONTADOR_EVENTOS_EN
  logic evento;
  always_comb begin
    evento = 1'b0;
    for (int i = 0; i < NUM_CANAIS; i++)
      evento = evento |
        (latch[2*i +: 2] == 2'b00 && latch_prox[2*i +: 2] != 2'b00) |
        (latch[2*i +: 2] == 2'b01 && latch_prox[2*i +: 2] == 2'b10);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) num_eventos <= '0;
    else if (evento && num_eventos != 8'hFF) num_eventos <= num_eventos + 1'b1;
  end
`endif
endmodule

// File: tb/tb_controlador_alerta_pressao.sv
// tb_controlador_alerta_pressao: random and directed scan stimulus checked against a history-based model.
module tb_controlador_alerta_pressao;
  localparam int NC = 4, CONF = 3, PER = 16, WT = PER - NC - 1;
  logic clk = 1'b0, rst_n = 1'b0, habilita = 1'b0, reconhece = 1'b0;
  logic [7:0] p [NC];
  logic [NC*8-1:0] pressao_in;
  logic [1:0] canal_atual;
  logic [2*NC-1:0] alerta_canal;
  logic [1:0] alerta;
  logic varredura_ok;
`ifdef CONTADOR_EVENTOS_EN
  logic [7:0] num_eventos;
`endif
  int nv = 0, nf = 0;
  int hist [NC][CONF];
  int lat [NC];
  int nl [NC];
  bit ativo = 0;
  int t = 0, nev = 0, ch, c, ev;
  bit run;
  logic [7:0] vals [9] = '{8'd0, 8'd30, 8'd49, 8'd50, 8'd100, 8'd149, 8'd150, 8'd200, 8'd255};
  assign pressao_in = {p[3], p[2], p[1], p[0]};
  always #5 clk = ~clk;
  controlador_alerta_pressao dut (
    .clk(clk), .rst_n(rst_n), .habilita(habilita), .pressao_in(pressao_in),
    .reconhece(reconhece), .canal_atual(canal_atual), .alerta_canal(alerta_canal),
    .alerta(alerta), .varredura_ok(varredura_ok)
`ifdef CONTADOR_EVENTOS_EN
    , .num_eventos(num_eventos)
`endif
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nv++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int cls(input logic [7:0] v);
    return v < 8'd50 ? 1 : (v >= 8'd150 ? 2 : 0);
  endfunction
  function automatic logic [7:0] lat_vec();
    logic [7:0] v;
    for (int i = 0; i < NC; i++) v[2*i +: 2] = 2'(lat[i]);
    return v;
  endfunction
  function automatic logic [1:0] agg();
    int h = 0, l = 0;
    for (int i = 0; i < NC; i++) begin
      if (lat[i] == 2) h = 1;
      if (lat[i] == 1) l = 1;
    end
    return h != 0 ? 2'b10 : (l != 0 ? 2'b01 : 2'b00);
  endfunction
  // an alarm confirms when the last CONF samples of a channel share one out-of-range class
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      ativo = 0; t = 0; nev = 0;
      for (int i = 0; i < NC; i++) begin
        lat[i] = 0;
        for (int k = 0; k < CONF; k++) hist[i][k] = 0;
      end
    end else begin
      for (int i = 0; i < NC; i++) nl[i] = (reconhece && hist[i][0] == 0) ? 0 : lat[i];
      if (!ativo) begin
        if (habilita) begin ativo = 1; t = 0; end
      end else if (!habilita) ativo = 0;
      else begin
        if (t >= WT && t < WT + NC) begin
          ch = t - WT;
          c = cls(p[ch]);
          for (int k = CONF - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
          hist[ch][0] = c;
          run = 1;
          for (int k = 0; k < CONF; k++) if (hist[ch][k] != c) run = 0;
          if (c != 0 && run && !(lat[ch] == 2 && c == 1)) nl[ch] = c;
        end
        t = (t + 1) % PER;
      end
      ev = 0;
      for (int i = 0; i < NC; i++) begin
        if ((lat[i] == 0 && nl[i] != 0) || (lat[i] == 1 && nl[i] == 2)) ev = 1;
        lat[i] = nl[i];
      end
      if (ev != 0 && nev < 255) nev++;
    end
  end
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("canal_atual", 32'(canal_atual), (ativo && t >= WT && t < WT + NC) ? t - WT : 0);
      chk("varredura_ok", 32'(varredura_ok), 32'(ativo && t == PER - 1));
      chk("alerta_canal", 32'(alerta_canal), 32'(lat_vec()));
      chk("alerta", 32'(alerta), 32'(agg()));
`ifdef CONTADOR_EVENTOS_EN
      chk("num_eventos", 32'(num_eventos), nev);
`endif
    end
  end
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_canal(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (canal_atual != 2'(k) && n < 64);
    chk("wait_canal", 32'(canal_atual), k);
  endtask
  initial begin
    int pulses;
    logic [7:0] seq;
    for (int i = 0; i < NC; i++) p[i] = 8'd100;
    cycles(3);
    chk("reset_alerta_canal", 32'(alerta_canal), 0);
    chk("reset_alerta", 32'(alerta), 0);
    chk("reset_ok", 32'(varredura_ok), 0);
    rst_n = 1'b1;
    cycles(2);
    habilita = 1'b1;
    pulses = 0;
    seq = '0;
    for (int k = 1; k <= 3 * PER; k++) begin
      @(negedge clk);
      pulses += int'(varredura_ok);
      if (k >= WT + 1 && k <= WT + NC) seq[2*(k-WT-1) +: 2] = canal_atual;
    end
    chk("pulses_3_scans", pulses, 3);
    chk("canal_sequence", 32'(seq), 32'h e4);
    p[1] = 8'd30;
    cycles(2 * PER);
    chk("two_lows_no_alarm", 32'(alerta_canal), 0);
    p[1] = 8'd100;
    cycles(PER);
    p[1] = 8'd30;
    cycles(3 * PER);
    chk("ch1_low_latched", 32'(alerta_canal), 32'h04);
    chk("agg_low", 32'(alerta), 32'h1);
    p[2] = 8'd150;
    for (int s = 0; s < 3; s++) begin
      p[0] = s[0] ? 8'd50 : 8'd49;
      cycles(PER);
    end
    chk("ch2_high_latched", 32'(alerta_canal), 32'h24);
    chk("agg_high", 32'(alerta), 32'h2);
    p[0] = 8'd100;
    p[2] = 8'd160;
    reconhece = 1'b1;
    cycles(PER);
    reconhece = 1'b0;
    chk("ack_keeps_high", 32'(alerta_canal[5:4]), 32'h2);
    p[2] = 8'd100;
    cycles(PER);
    reconhece = 1'b1;
    cycles(1);
    reconhece = 1'b0;
    chk("ack_clears_ch2", 32'(alerta_canal), 32'h04);
    chk("agg_after_ack", 32'(alerta), 32'h1);
    reconhece = 1'b1;
    p[3] = 8'd200;
    cycles(3 * PER);
    reconhece = 1'b0;
    chk("set_wins_over_ack", 32'(alerta_canal), 32'h84);
    p[3] = 8'd100;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 23) == 0) p[$urandom_range(0, NC-1)] = vals[$urandom_range(0, 8)];
      reconhece = $urandom_range(0, 9) == 0;
      habilita = habilita ? ($urandom_range(0, 79) != 0) : ($urandom_range(0, 3) == 0);
    end
    habilita = 1'b1;
    reconhece = 1'b0;
    p[1] = 8'd30;
    cycles(3 * PER);
    wait_canal(2);
    habilita = 1'b0;
    cycles(1);
    chk("abort_canal", 32'(canal_atual), 0);
    chk("abort_no_ok", 32'(varredura_ok), 0);
    habilita = 1'b1;
    wait_canal(1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_canal", 32'(canal_atual), 0);
    chk("async_alerta_canal", 32'(alerta_canal), 0);
    chk("async_alerta", 32'(alerta), 0);
    chk("async_ok", 32'(varredura_ok), 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(3 * PER);
    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end
endmodule
